// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock sequencer that gates the system reset release
// Pulses pll_rst, waits for a debounced lock, then releases sys_rst_n; restarts on loss/timeout/request.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int SYNC_STAGES   = 2,
  parameter int RETRY_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               soft_rst_req,
  input  logic               lock_lost_clr,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CW        = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_WAIT = 2'd1,
    S_STAB = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CW-1:0]            r_cnt;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     w_lock_s;
  logic                     w_cnt_clr;
  logic                     w_retry_inc;
  logic                     w_lost_set;
  logic                     r_pll_rst;
  logic                     r_sys_rst_n;
  logic                     r_ready;
  logic                     r_lock_lost;
  logic [RETRY_W-1:0]       r_retry_cnt;

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_inc = 1'b0;
    w_lost_set  = 1'b0;
    unique case (r_state)
      S_RST: begin
        if (r_cnt == RST_LAST) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_lock_s) begin
          w_state_nxt = S_STAB;
        end else if (r_cnt == WAIT_LAST) begin
          w_state_nxt = S_RST;
          w_retry_inc = 1'b1;
        end
      end
      S_STAB: begin
        if (!w_lock_s)                w_state_nxt = S_WAIT;
        else if (r_cnt == STAB_LAST)  w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = S_RST;
          w_lost_set  = 1'b1;
        end
      end
      default: w_state_nxt = S_RST;
    endcase
    // A software request overrides everything, including the lock-loss flag and retry count.
    if (soft_rst_req) begin
      w_state_nxt = S_RST;
      w_retry_inc = 1'b0;
      w_lost_set  = 1'b0;
    end
  end

  // Re-requesting while already in S_RST restarts the count, stretching the pll_rst pulse.
  assign w_cnt_clr = (w_state_nxt != r_state) || soft_rst_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RST;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      r_pll_rst   <= (w_state_nxt == S_RST);
      r_sys_rst_n <= (w_state_nxt == S_RUN);
      r_ready     <= (w_state_nxt == S_RUN);
      if (w_lost_set)         r_lock_lost <= 1'b1;
      else if (lock_lost_clr) r_lock_lost <= 1'b0;
      if (w_retry_inc && (r_retry_cnt != {RETRY_W{1'b1}}))
        r_retry_cnt <= r_retry_cnt + 1'b1;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign ready     = r_ready;
  assign lock_lost = r_lock_lost;
  assign retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       lock_lost_clr = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .SYNC_STAGES  (2),
    .RETRY_W      (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .soft_rst_req (soft_rst_req),
    .lock_lost_clr(lock_lost_clr),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic lock_val);
    rst_n = 1'b0;
    soft_rst_req = 1'b0;
    lock_lost_clr = 1'b0;
    pll_lock = lock_val;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_run(inout int n, input int limit);
    while (!sys_rst_n && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;

    // 1: lock high throughout
    do_reset(1'b1);
    check("rst_pll_rst", 32'(pll_rst), 1);
    check("rst_sys_rst_n", 32'(sys_rst_n), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_lock_lost", 32'(lock_lost), 0);
    check("rst_retry", 32'(retry_cnt), 0);
    tick(); tick(); tick();
    check("t1_pll_rst_e3", 32'(pll_rst), 1);
    tick();
    check("t1_pll_rst_e4", 32'(pll_rst), 0);
    n = 4;
    wait_run(n, 200);
    check("t1_run_latency", 32'(n), 13);
    check("t1_ready", 32'(ready), 1);
    check("t1_lock_lost", 32'(lock_lost), 0);
    check("t1_retry", 32'(retry_cnt), 0);

    // 2: lock never arrives, retries every RST_CYCLES+LOCK_TIMEOUT cycles
    do_reset(1'b0);
    for (int e = 1; e <= 24 * 17; e++) begin
      tick();
      check("t2_pll_rst", 32'(pll_rst), ((e % 24) < 4) ? 1 : 0);
      check("t2_retry", 32'(retry_cnt), ((e / 24) > 15) ? 15 : (e / 24));
    end
    check("t2_sys_rst_n", 32'(sys_rst_n), 0);

    // 3: lock glitch during STAB
    do_reset(1'b0);
    for (int e = 0; e < 6; e++) tick();
    pll_lock = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 12;
    wait_run(n, 200);
    check("t3_run_edge", 32'(n), 23);

    // 4: lock loss in RUN
    pll_lock = 1'b0;
    tick(); tick();
    check("t4_still_run", 32'(sys_rst_n), 1);
    tick();
    check("t4_sys_rst_n", 32'(sys_rst_n), 0);
    check("t4_ready", 32'(ready), 0);
    check("t4_pll_rst", 32'(pll_rst), 1);
    check("t4_lock_lost", 32'(lock_lost), 1);
    pll_lock = 1'b1;
    n = 0;
    wait_run(n, 200);
    check("t4_relock_latency", 32'(n), 13);
    check("t4_lost_sticky", 32'(lock_lost), 1);
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    check("t4_lost_cleared", 32'(lock_lost), 0);
    check("t4_run_after_clr", 32'(sys_rst_n), 1);

    // 5: software re-reset, re-requested two cycles later
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("t5_pll_rst", 32'(pll_rst), 1);
    check("t5_sys_rst_n", 32'(sys_rst_n), 0);
    check("t5_ready", 32'(ready), 0);
    check("t5_lock_lost", 32'(lock_lost), 0);
    tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("t5_pll_rst_p2", 32'(pll_rst), 1);
    tick(); tick();
    check("t5_pll_rst_ext2", 32'(pll_rst), 1);
    tick();
    check("t5_pll_rst_ext3", 32'(pll_rst), 1);
    tick();
    check("t5_pll_rst_end", 32'(pll_rst), 0);
    n = 0;
    wait_run(n, 200);
    check("t5_run_latency", 32'(n), 9);

    // 6a: lock-loss set and clear in the same cycle
    pll_lock = 1'b0;
    tick(); tick();
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    check("t6_set_wins", 32'(lock_lost), 1);
    check("t6_pll_rst", 32'(pll_rst), 1);
    pll_lock = 1'b1;
    for (int e = 0; e < 7; e++) tick();
    check("t6_stab_pll_rst", 32'(pll_rst), 0);
    check("t6_stab_sys_rst_n", 32'(sys_rst_n), 0);

    // 6b: async reset mid-STAB
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_pll_rst", 32'(pll_rst), 1);
    check("t6_async_lock_lost", 32'(lock_lost), 0);
    check("t6_async_sys_rst_n", 32'(sys_rst_n), 0);
    check("t6_async_ready", 32'(ready), 0);
    check("t6_async_retry", 32'(retry_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
